// File: rtl/cu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cu_op_sequencer
// Purpose  : In-order issue scheduler for ALU/MUL/SHF ops with RAW and
//            write-back collision stalls, request FIFO and in-flight tracking.
// Revision : 1.0
// ============================================================================
module cu_op_sequencer #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int SIGNAL_WIDTH  = 3,
  parameter int CTL_WIDTH     = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int ALU_LAT       = 1,
  parameter int SHF_LAT       = 1,
  parameter int MUL_LAT       = 2
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [1:0]               req_unit_i,
  input  logic [ADDRESS_WIDTH-1:0] req_rx_i,
  input  logic [ADDRESS_WIDTH-1:0] req_ry_i,
  input  logic [ADDRESS_WIDTH-1:0] req_rd_i,
  input  logic [CTL_WIDTH-1:0]     req_ctl_i,
  output logic                     seq_alu_en_o,
  output logic                     seq_mul_en_o,
  output logic                     seq_shf_en_o,
  output logic [CTL_WIDTH-1:0]     seq_ctl_o,
  output logic [ADDRESS_WIDTH-1:0] seq_raddx_o,
  output logic [ADDRESS_WIDTH-1:0] seq_raddy_o,
  output logic [SIGNAL_WIDTH-1:0]  seq_w_cuEn_o,
  output logic [ADDRESS_WIDTH-1:0] seq_wadd_o,
  output logic                     seq_busy_o,
  output logic                     seq_err_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] FU_ALU = 2'b00;
  localparam logic [1:0] FU_MUL = 2'b01;
  localparam logic [1:0] FU_SHF = 2'b10;
  localparam logic [1:0] FU_RSV = 2'b11;

  typedef struct packed {
    logic [1:0]               fu;
    logic [ADDRESS_WIDTH-1:0] rx;
    logic [ADDRESS_WIDTH-1:0] ry;
    logic [ADDRESS_WIDTH-1:0] rd;
    logic [CTL_WIDTH-1:0]     ctl;
  } req_t;

  typedef struct packed {
    logic                     valid;
    logic [1:0]               fu;
    logic [ADDRESS_WIDTH-1:0] rd;
  } pend_t;

  function automatic int lat_of(input logic [1:0] fu);
    case (fu)
      FU_ALU:  lat_of = ALU_LAT;
      FU_MUL:  lat_of = MUL_LAT;
      FU_SHF:  lat_of = SHF_LAT;
      default: lat_of = 0;
    endcase
  endfunction

  req_t                    fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]        count_q, count_d;
  // Slot k holds the op that writes back k cycles from now.
  pend_t                   pend_q [1:MUL_LAT];
  pend_t                   pend_d [1:MUL_LAT];
  pend_t                   wb_d;
  logic                    busy_d;

  logic                    req_ready_q;
  logic                    alu_en_q, mul_en_q, shf_en_q;
  logic [CTL_WIDTH-1:0]    ctl_q;
  logic [ADDRESS_WIDTH-1:0] raddx_q, raddy_q, wadd_q;
  logic [SIGNAL_WIDTH-1:0] w_cuen_q;
  logic                    busy_q, err_q;

  req_t                    w_head;
  int                      w_lat;
  logic                    w_empty, w_raw, w_coll, w_discard, w_issue, w_pop, w_push;

  always_comb begin
    w_head    = fifo_mem[rd_ptr_q];
    w_empty   = (count_q == '0);
    w_lat     = lat_of(w_head.fu);
    w_raw     = 1'b0;
    w_coll    = 1'b0;
    for (int k = 1; k <= MUL_LAT; k++) begin
      if (pend_q[k].valid && (pend_q[k].rd == w_head.rx || pend_q[k].rd == w_head.ry))
        w_raw = 1'b1;
      // Issuing next cycle lands this op in slot w_lat, i.e. today's slot w_lat+1.
      if (pend_q[k].valid && (k == w_lat + 1))
        w_coll = 1'b1;
    end
    w_discard = !w_empty && (w_head.fu == FU_RSV);
    w_issue   = !w_empty && !w_discard && !w_raw && !w_coll;
    w_pop     = w_issue || w_discard;
    w_push    = req_valid_i && req_ready_q;
    count_d   = count_q + CNT_W'(w_push) - CNT_W'(w_pop);

    wb_d = pend_q[1];
    for (int k = 1; k <= MUL_LAT; k++) pend_d[k] = '0;
    for (int k = 1; k < MUL_LAT; k++) pend_d[k] = pend_q[k+1];
    if (w_issue) begin
      for (int k = 1; k <= MUL_LAT; k++) begin
        if (k == w_lat) begin
          pend_d[k].valid = 1'b1;
          pend_d[k].fu    = w_head.fu;
          pend_d[k].rd    = w_head.rd;
        end
      end
    end

    busy_d = (count_d != '0) || wb_d.valid || w_issue;
    for (int k = 1; k <= MUL_LAT; k++) busy_d = busy_d || pend_d[k].valid;
  end

  always_ff @(posedge clk_i) begin
    if (w_push) fifo_mem[wr_ptr_q] <= '{fu: req_unit_i, rx: req_rx_i, ry: req_ry_i,
                                        rd: req_rd_i, ctl: req_ctl_i};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int k = 1; k <= MUL_LAT; k++) pend_q[k] <= '0;
      req_ready_q <= 1'b0;
      alu_en_q    <= 1'b0;
      mul_en_q    <= 1'b0;
      shf_en_q    <= 1'b0;
      ctl_q       <= '0;
      raddx_q     <= '0;
      raddy_q     <= '0;
      w_cuen_q    <= '0;
      wadd_q      <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_q + PTR_W'(w_push);
      rd_ptr_q    <= rd_ptr_q + PTR_W'(w_pop);
      count_q     <= count_d;
      for (int k = 1; k <= MUL_LAT; k++) pend_q[k] <= pend_d[k];
      req_ready_q <= (count_d != CNT_W'(FIFO_DEPTH));
      alu_en_q    <= w_issue && (w_head.fu == FU_ALU);
      mul_en_q    <= w_issue && (w_head.fu == FU_MUL);
      shf_en_q    <= w_issue && (w_head.fu == FU_SHF);
      ctl_q       <= w_issue ? w_head.ctl : '0;
      raddx_q     <= w_issue ? w_head.rx : '0;
      raddy_q     <= w_issue ? w_head.ry : '0;
      w_cuen_q    <= wb_d.valid ? (SIGNAL_WIDTH'(1) << wb_d.fu) : '0;
      wadd_q      <= wb_d.valid ? wb_d.rd : '0;
      busy_q      <= busy_d;
      err_q       <= w_discard;
    end
  end

  assign req_ready_o  = req_ready_q;
  assign seq_alu_en_o = alu_en_q;
  assign seq_mul_en_o = mul_en_q;
  assign seq_shf_en_o = shf_en_q;
  assign seq_ctl_o    = ctl_q;
  assign seq_raddx_o  = raddx_q;
  assign seq_raddy_o  = raddy_q;
  assign seq_w_cuEn_o = w_cuen_q;
  assign seq_wadd_o   = wadd_q;
  assign seq_busy_o   = busy_q;
  assign seq_err_o    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_cu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cu_op_sequencer
// Purpose  : Directed scoreboard bench for cu_op_sequencer issue/write-back timing.
// Revision : 1.0
// ============================================================================
module tb_cu_op_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_unit;
  logic [3:0] req_rx, req_ry, req_rd;
  logic [7:0] req_ctl;
  logic       alu_en, mul_en, shf_en;
  logic [7:0] seq_ctl;
  logic [3:0] raddx, raddy, wadd;
  logic [2:0] w_cuen;
  logic       busy, err;

  cu_op_sequencer dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_unit_i   (req_unit),
    .req_rx_i     (req_rx),
    .req_ry_i     (req_ry),
    .req_rd_i     (req_rd),
    .req_ctl_i    (req_ctl),
    .seq_alu_en_o (alu_en),
    .seq_mul_en_o (mul_en),
    .seq_shf_en_o (shf_en),
    .seq_ctl_o    (seq_ctl),
    .seq_raddx_o  (raddx),
    .seq_raddy_o  (raddy),
    .seq_w_cuEn_o (w_cuen),
    .seq_wadd_o   (wadd),
    .seq_busy_o   (busy),
    .seq_err_o    (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [2:0] en;
    logic [3:0] rx;
    logic [3:0] ry;
    logic [7:0] ctl;
  } iss_t;

  typedef struct {
    int         cyc;
    logic [2:0] en;
    logic [3:0] rd;
  } wb_t;

  iss_t iss_q[$];
  wb_t  wb_q[$];
  int   err_q[$];

  int   errors = 0;
  int   checks = 0;
  logic mon_en = 1'b0;

  localparam logic [1:0] ALU = 2'b00, MUL = 2'b01, SHF = 2'b10, RSV = 2'b11;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected issue at cycle ci; write-back follows after the unit latency.
  task automatic exp_op(input int ci, input logic [1:0] u, input logic [3:0] rx, input logic [3:0] ry,
                        input logic [3:0] rd, input logic [7:0] ctl, input bit with_wb);
    iss_t e;
    wb_t  w;
    e.cyc = ci; e.en = 3'b001 << u; e.rx = rx; e.ry = ry; e.ctl = ctl;
    iss_q.push_back(e);
    if (with_wb) begin
      w.cyc = ci + ((u == MUL) ? 2 : 1); w.en = e.en; w.rd = rd;
      wb_q.push_back(w);
    end
  endtask

  task automatic push(input logic [1:0] u, input logic [3:0] rx, input logic [3:0] ry,
                      input logic [3:0] rd, input logic [7:0] ctl, input int exp_acc);
    bit done;
    done = 1'b0;
    req_valid = 1'b1; req_unit = u; req_rx = rx; req_ry = ry; req_rd = rd; req_ctl = ctl;
    for (int i = 0; i < 20 && !done; i++) begin
      if (req_ready) begin
        chk("accept_cycle", cyc, exp_acc);
        done = 1'b1;
      end
      step();
    end
    if (!done) chk("accept_timeout", cyc, exp_acc);
  endtask

  task automatic idle();
    req_valid = 1'b0; req_unit = '0; req_rx = '0; req_ry = '0; req_rd = '0; req_ctl = '0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && busy; i++) step();
    chk("drain_busy", busy, 1'b0);
    step();
    step();
  endtask

  // Scoreboard side: every enable / write-back / error pulse consumes one expectation.
  logic [2:0] m_en;
  iss_t       m_i;
  wb_t        m_w;
  int         m_c;
  always @(negedge clk) begin
    if (mon_en) begin
      m_en = {shf_en, mul_en, alu_en};
      if (m_en != 3'b000) begin
        if (iss_q.size() == 0) chk("unexpected_issue", m_en, 3'b000);
        else begin
          m_i = iss_q.pop_front();
          chk("issue_cycle", cyc, m_i.cyc);
          chk("issue_unit", m_en, m_i.en);
          chk("issue_raddx", raddx, m_i.rx);
          chk("issue_raddy", raddy, m_i.ry);
          chk("issue_ctl", seq_ctl, m_i.ctl);
        end
      end
      if (w_cuen != 3'b000) begin
        if (wb_q.size() == 0) chk("unexpected_wb", w_cuen, 3'b000);
        else begin
          m_w = wb_q.pop_front();
          chk("wb_cycle", cyc, m_w.cyc);
          chk("wb_unit", w_cuen, m_w.en);
          chk("wb_addr", wadd, m_w.rd);
        end
      end
      if (err) begin
        if (err_q.size() == 0) chk("unexpected_err", err, 1'b0);
        else begin
          m_c = err_q.pop_front();
          chk("err_cycle", cyc, m_c);
        end
      end
    end
  end

  int b;

  initial begin
    reset = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {req_ready, alu_en, mul_en, shf_en, seq_ctl, raddx, raddy, w_cuen, wadd, busy, err}, '0);
    reset = 1'b0;
    step();
    chk("ready_after_reset", req_ready, 1'b1);
    mon_en = 1'b1;
    step();

    // Back-to-back independent ALU ops.
    b = cyc;
    exp_op(b + 2, ALU, 4'd2, 4'd3, 4'd1, 8'hA1, 1);
    exp_op(b + 3, ALU, 4'd5, 4'd6, 4'd4, 8'hA2, 1);
    push(ALU, 4'd2, 4'd3, 4'd1, 8'hA1, b);
    push(ALU, 4'd5, 4'd6, 4'd4, 8'hA2, b + 1);
    idle();
    chk("busy_inflight", busy, 1'b1);
    wait_idle();

    // MUL rd=7 then dependent ALU: waits for the MUL write-back.
    b = cyc;
    exp_op(b + 2, MUL, 4'd1, 4'd2, 4'd7, 8'hB1, 1);
    exp_op(b + 5, ALU, 4'd7, 4'd3, 4'd8, 8'hB2, 1);
    push(MUL, 4'd1, 4'd2, 4'd7, 8'hB1, b);
    push(ALU, 4'd7, 4'd3, 4'd8, 8'hB2, b + 1);
    idle();
    wait_idle();

    // MUL then independent ALU: write-back port collision forces one stall.
    b = cyc;
    exp_op(b + 2, MUL, 4'd2, 4'd3, 4'd1, 8'hC1, 1);
    exp_op(b + 4, ALU, 4'd4, 4'd5, 4'd2, 8'hC2, 1);
    push(MUL, 4'd2, 4'd3, 4'd1, 8'hC1, b);
    push(ALU, 4'd4, 4'd5, 4'd2, 8'hC2, b + 1);
    idle();
    wait_idle();

    // Dependent MUL chain fills the FIFO; ready drops and recovers after a pop.
    b = cyc;
    exp_op(b + 2, MUL, 4'd14, 4'd15, 4'd1, 8'h10, 1);
    for (int i = 1; i <= 6; i++)
      exp_op(b + 2 + 3 * i, MUL, 4'(i), 4'd15, 4'(i + 1), 8'(8'h10 + i), 1);
    push(MUL, 4'd14, 4'd15, 4'd1, 8'h10, b);
    for (int i = 1; i <= 5; i++)
      push(MUL, 4'(i), 4'd15, 4'(i + 1), 8'(8'h10 + i), b + i);
    chk("ready_full", req_ready, 1'b0);
    push(MUL, 4'd6, 4'd15, 4'd7, 8'h16, b + 8);
    idle();
    wait_idle();

    // Reserved unit between two ALU ops.
    b = cyc;
    exp_op(b + 2, ALU, 4'd2, 4'd3, 4'd1, 8'hD1, 1);
    err_q.push_back(b + 3);
    exp_op(b + 4, ALU, 4'd5, 4'd6, 4'd4, 8'hD3, 1);
    push(ALU, 4'd2, 4'd3, 4'd1, 8'hD1, b);
    push(RSV, 4'd0, 4'd0, 4'd0, 8'hFF, b + 1);
    push(ALU, 4'd5, 4'd6, 4'd4, 8'hD3, b + 2);
    idle();
    wait_idle();

    // Reset the cycle after a MUL issue: its write-back and a queued op vanish.
    b = cyc;
    exp_op(b + 2, MUL, 4'd1, 4'd2, 4'd3, 8'hE1, 0);
    push(MUL, 4'd1, 4'd2, 4'd3, 8'hE1, b);
    push(ALU, 4'd3, 4'd0, 4'd5, 8'hE2, b + 1);
    idle();
    step();
    reset = 1'b1;
    step();
    chk("midreset_outputs", {req_ready, alu_en, mul_en, shf_en, seq_ctl, raddx, raddy, w_cuen, wadd, busy, err}, '0);
    reset = 1'b0;
    step();
    chk("midreset_ready", req_ready, 1'b1);
    chk("midreset_busy", busy, 1'b0);
    repeat (6) step();

    chk("issues_left", iss_q.size(), 0);
    chk("wbs_left", wb_q.size(), 0);
    chk("errs_left", err_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
